// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Front-end fetch stage for the 3-bit-opcode processor.
//                Contains a loadable instruction memory and a PC that walks
//                a program of prog_len words. Each fetched word is presented
//                in an IF/ID register (instr, opcode, instr_valid). A stall
//                input from downstream freezes the stage. A four-state FSM
//                (IDLE/RUN/LAST/DONE) sequences loading, fetching, draining
//                and completion.
//  Ports       : clk, rst            - clock and synchronous active-high reset
//                load_we/addr/data   - memory write port (IDLE/DONE only)
//                start, prog_len     - launch a program of prog_len words
//                stall               - downstream not ready, hold the stage
//                pc                  - address of the next word to fetch
//                instr, opcode       - IF/ID register and its top 3 bits
//                instr_valid         - instr holds an unconsumed instruction
//                busy, done          - RUN/LAST indicator, sticky completion
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int IW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          stall,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] instr,
  output logic [2:0]    opcode,
  output logic          instr_valid,
  output logic          busy,
  output logic          done
);

  localparam int         c_depth_words = 1 << AW;
  localparam logic [AW:0] c_depth      = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] c_one        = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [AW:0]   len_q, len_d;

  logic [IW-1:0] mem_q [c_depth_words];
  logic          mem_we;
  logic [AW:0]   len_clamped;
  logic          at_last_addr;

  // Lengths beyond the memory depth would otherwise make the PC wrap.
  assign len_clamped  = (prog_len > c_depth) ? c_depth : prog_len;
  // len_q is at least 1 whenever this is used (RUN only).
  assign at_last_addr = ({1'b0, pc_q} == (len_q - c_one));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;
    len_d   = len_q;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        valid_d = 1'b0;
        mem_we  = load_we;
        if (start) begin
          len_d = len_clamped;
          if (len_clamped == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            pc_d    = '0;
            done_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (!stall) begin
          instr_d = mem_q[pc_q];
          valid_d = 1'b1;
          // The PC parks on the final address rather than advancing past it.
          if (at_last_addr) begin
            state_d = ST_LAST;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      ST_LAST: begin
        // Final word is on instr; it retires when downstream accepts it.
        if (!stall) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      len_q   <= len_d;
    end
  end

  // Memory contents survive reset; only the write is suppressed while in reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[IW-1 -: 3];
  assign instr_valid = valid_q;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_LAST);
  assign done        = done_q;

endmodule
`default_nettype wire
